// File: rtl/reg_bank_scan.sv
// ---------------------------------------------------------------------------
// reg_bank_scan
//   16-entry x N-bit register bank with a scan sequencer feeding a 16:1
//   output mux. Entries are written through a simple write port while the
//   sequencer is not scanning. A scan presents entries 0..LAST one at a time
//   on sel under a valid/ready handshake.
//
// Optional feature macro: SCAN_SKIP_ZERO_EN
//   defined   : zero-valued entries are not offered. Each one costs exactly
//               one cycle with out_valid=0 and advances sel without out_ready.
//   undefined : every entry 0..LAST is offered.
//
// Parameters
//   N     data width of each entry
//   LAST  highest scanned index (1..15)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   wr_en      write strobe
//   wr_addr    write index
//   wr_data    write data
//   wr_err     one-cycle pulse: a write was dropped because busy was high
//   start      begin a scan (honoured in IDLE only)
//   loop       continuous mode: wrap LAST->0 instead of finishing
//   abort      synchronous scan cancel (honoured in SCAN only)
//   sel        index presented to the mux select
//   bank_flat  entry k at bits [k*N +: N], direct register view
//   out_valid  entry at sel is offered
//   out_ready  consumer accepts the entry at sel
//   busy       high in SCAN
//   done       one-cycle pulse: scan completed, or wrapped in loop mode
// ---------------------------------------------------------------------------
module reg_bank_scan #(
    parameter int N    = 8,
    parameter int LAST = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [3:0]      wr_addr,
    input  logic [N-1:0]    wr_data,
    output logic            wr_err,
    input  logic            start,
    input  logic            loop,
    input  logic            abort,
    output logic [3:0]      sel,
    output logic [16*N-1:0] bank_flat,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [3:0] LAST_IDX = 4'(LAST);

    logic [N-1:0] r_bank [16];
    logic [1:0]   r_state;
    logic [3:0]   r_sel;
    logic         r_done;
    logic         r_wr_err;

    logic         w_scan;
    logic [N-1:0] w_entry;
    logic         w_skip;
    logic         w_offer;
    logic         w_advance;
    logic         w_wr_ok;
    logic [1:0]   w_state_nxt;
    logic [3:0]   w_sel_nxt;
    logic         w_done_nxt;

    assign w_scan  = (r_state == ST_SCAN);
    assign w_entry = r_bank[r_sel];

`ifdef SCAN_SKIP_ZERO_EN
    // A zero entry is stepped over in one cycle without being offered.
    assign w_skip = w_scan & (w_entry == {N{1'b0}});
`else
    assign w_skip = 1'b0;
`endif

    assign w_offer   = w_scan & ~w_skip;
    assign w_advance = w_skip | (w_offer & out_ready);
    // Bank is frozen during a scan so the offered data never changes under valid.
    assign w_wr_ok   = wr_en & ~w_scan;

    // Next-state, next-select and done-pulse decode for the scan sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // start wins over abort here because abort only acts in SCAN.
                if (start) begin
                    w_state_nxt = ST_SCAN;
                    w_sel_nxt   = 4'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = 4'd0;
                end else if (w_advance) begin
                    if (r_sel == LAST_IDX) begin
                        w_done_nxt = 1'b1;
                        if (loop) begin
                            w_sel_nxt = 4'd0;
                        end else begin
                            // sel stays on LAST through DONE and the following IDLE.
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_sel_nxt = r_sel + 4'd1;
                    end
                end else begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = 4'd0;
            end
        endcase
    end

    // Sequencer state, select and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sel    <= 4'd0;
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_done   <= w_done_nxt;
            r_wr_err <= wr_en & w_scan;
        end
    end

    // Register bank storage; contents are lost on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
                r_bank[k] <= {N{1'b0}};
            end
        end else begin
            if (w_wr_ok) begin
                r_bank[wr_addr] <= wr_data;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_flat
            assign bank_flat[g*N +: N] = r_bank[g];
        end
    endgenerate

    // Status outputs decode directly from registered state so that reset
    // clears them in the same cycle.
    assign sel       = r_sel;
    assign busy      = w_scan;
    assign out_valid = w_offer;
    assign done      = r_done;
    assign wr_err    = r_wr_err;

endmodule
